// File: rtl/ram_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared constants for the two-port SRAM arbiter (port
//               indices, byte-enable codes, SRAM geometry).
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    // SRAM geometry: 4096 words of 32 bits
    localparam int RAM_AW = 12;
    localparam int RAM_DW = 32;

    // Requester indices
    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DMA  = 1'b1;

    // Byte-enable codes driven onto the SRAM
    localparam logic [3:0] BEN_NONE = 4'b0000;
    localparam logic [3:0] BEN_WORD = 4'b1111;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/ram_arb_rdport.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ram_arb_rdport
// Description : Per-port read return. Shows SRAM data on the return cycle
//               and holds the last returned word until the next return.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arb_rdport
    import ram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ret,        // pending read belongs to this port
    input  logic [RAM_DW-1:0] i_sram_dout,
    output logic              o_rvalid,
    output logic [RAM_DW-1:0] o_rdata
);

    logic [RAM_DW-1:0] r_hold;
    logic              w_rvalid;

    // A reset arriving while a read is in flight discards that read
    assign w_rvalid = i_ret & ~rst;

    // Capture returned data so the port keeps seeing it between returns
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (w_rvalid) begin
            r_hold <= i_sram_dout;
        end
    end

    assign o_rvalid = w_rvalid;
    assign o_rdata  = w_rvalid ? i_sram_dout : r_hold;

endmodule : ram_arb_rdport
`default_nettype wire

// File: rtl/ram_arb2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ram_arb2
// Description : Two-port arbiter/sequencer in front of the single-port
//               32x4096 SRAM. Port 0 = core data, port 1 = DMA/debug.
//               Combinational grant, one access per cycle, one-cycle read
//               return with per-port hold of the last read word.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arb2
    import ram_arb_pkg::*;
#(
    parameter int PRIO_MODE = 0,    // 0: round-robin, 1: port 0 fixed priority
    parameter int LOCK_MAX  = 8     // locked grants allowed while other waits
)(
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [RAM_AW-1:0] p0_addr,
    input  logic [RAM_DW-1:0] p0_wdata,
    input  logic [3:0]        p0_ben,
    input  logic              p0_lock,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [RAM_DW-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [RAM_AW-1:0] p1_addr,
    input  logic [RAM_DW-1:0] p1_wdata,
    input  logic [3:0]        p1_ben,
    input  logic              p1_lock,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [RAM_DW-1:0] p1_rdata,

    output logic [RAM_AW-1:0] sram_addr,
    output logic [RAM_DW-1:0] sram_din,
    output logic [3:0]        sram_ben,
    output logic              sram_wren,
    input  logic [RAM_DW-1:0] sram_dout
);

    localparam logic [7:0] c_lock_max = 8'(LOCK_MAX);

    // Arbitration state
    logic              r_last_gnt;      // port granted most recently
    logic              r_prev_gnt;      // a grant was issued last cycle
    logic [7:0]        r_lock_cnt;
    // Pending read {valid, port}
    logic              r_rd_pend_vld;
    logic              r_rd_pend_port;
    // Idle values of the SRAM address/data bus
    logic [RAM_AW-1:0] r_addr;
    logic [RAM_DW-1:0] r_din;

    logic              w_both;
    logic              w_any;
    logic              w_lock_active;
    logic              w_win;
    logic              w_we;
    logic              w_win_lock;
    logic [RAM_AW-1:0] w_addr;
    logic [RAM_DW-1:0] w_wdata;
    logic [3:0]        w_ben;

    assign w_both = p0_req & p1_req;
    assign w_any  = (p0_req | p1_req) & ~rst;

    // The previous winner keeps the port while it asserts lock, until the cap
    assign w_lock_active = r_prev_gnt
                         & (r_last_gnt ? (p1_req & p1_lock) : (p0_req & p0_lock))
                         & (r_lock_cnt < c_lock_max);

    // Winner selection and winner command mux
    always_comb begin
        w_win = PORT_CORE;
        if (w_both) begin
            if (w_lock_active) begin
                w_win = r_last_gnt;
            end else if (PRIO_MODE == 1) begin
                w_win = PORT_CORE;
            end else begin
                w_win = ~r_last_gnt;
            end
        end else if (p1_req) begin
            w_win = PORT_DMA;
        end

        w_we       = (w_win == PORT_DMA) ? p1_we    : p0_we;
        w_addr     = (w_win == PORT_DMA) ? p1_addr  : p0_addr;
        w_wdata    = (w_win == PORT_DMA) ? p1_wdata : p0_wdata;
        w_ben      = (w_win == PORT_DMA) ? p1_ben   : p0_ben;
        w_win_lock = (w_win == PORT_DMA) ? p1_lock  : p0_lock;
    end

    assign p0_gnt = w_any & (w_win == PORT_CORE);
    assign p1_gnt = w_any & (w_win == PORT_DMA);

    // Reads always fetch the whole word; idle keeps addr/din, drops strobes
    assign sram_addr = w_any ? w_addr : r_addr;
    assign sram_din  = (w_any & w_we) ? w_wdata : r_din;
    assign sram_wren = w_any & w_we;
    assign sram_ben  = !w_any ? BEN_NONE : (w_we ? w_ben : BEN_WORD);

    // Arbitration history and locked-grant counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt <= PORT_DMA;
            r_prev_gnt <= 1'b0;
            r_lock_cnt <= 8'd0;
        end else begin
            r_prev_gnt <= w_any;
            if (w_any) begin
                r_last_gnt <= w_win;
            end
            if (w_any && w_both && w_win_lock) begin
                if (r_prev_gnt && (w_win == r_last_gnt)) begin
                    r_lock_cnt <= (r_lock_cnt == 8'hFF) ? r_lock_cnt : r_lock_cnt + 8'd1;
                end else begin
                    r_lock_cnt <= 8'd1;
                end
            end else begin
                r_lock_cnt <= 8'd0;
            end
        end
    end

    // Remember the read issued this cycle and the last bus values
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend_vld  <= 1'b0;
            r_rd_pend_port <= PORT_CORE;
            r_addr         <= '0;
            r_din          <= '0;
        end else begin
            r_rd_pend_vld  <= w_any & ~w_we;
            r_rd_pend_port <= w_win;
            if (w_any) begin
                r_addr <= w_addr;
            end
            if (w_any && w_we) begin
                r_din <= w_wdata;
            end
        end
    end

    ram_arb_rdport u_rdport0 (
        .clk         (clk),
        .rst         (rst),
        .i_ret       (r_rd_pend_vld & (r_rd_pend_port == PORT_CORE)),
        .i_sram_dout (sram_dout),
        .o_rvalid    (p0_rvalid),
        .o_rdata     (p0_rdata)
    );

    ram_arb_rdport u_rdport1 (
        .clk         (clk),
        .rst         (rst),
        .i_ret       (r_rd_pend_vld & (r_rd_pend_port == PORT_DMA)),
        .i_sram_dout (sram_dout),
        .o_rvalid    (p1_rvalid),
        .o_rdata     (p1_rdata)
    );

endmodule : ram_arb2
`default_nettype wire
